// File: rtl/modbus_rtu_frame_check.sv
// Receive-side Modbus RTU frame checker: bit-serial CRC-16 over every byte of a
// frame, then a one-shot verdict (CRC residue, length, address, line errors).
module modbus_rtu_frame_check #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h01,
  parameter int unsigned MIN_LEN    = 4,
  parameter int unsigned MAX_LEN    = 256,
  parameter int unsigned LEN_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rx_err,
  input  logic             frame_end,
  output logic             done,
  output logic             frame_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic             err_seen,
  output logic             addr_match,
  output logic             broadcast,
  output logic [LEN_W-1:0] frame_len,
  output logic [15:0]      crc_residue
);

  localparam logic [15:0]      CRC_INIT = 16'hFFFF;
  localparam logic [15:0]      CRC_POLY = 16'hA001;
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      crc, crc_nxt;
  logic [LEN_W-1:0] count, count_nxt;
  logic [7:0]       addr, addr_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic             end_pend, end_pend_nxt;
  logic             err_pend, err_pend_nxt;

  logic             in_ready_nxt, done_nxt, frame_ok_nxt, crc_err_nxt, len_err_nxt;
  logic             err_seen_nxt, addr_match_nxt, broadcast_nxt;
  logic [LEN_W-1:0] frame_len_nxt;
  logic [15:0]      crc_residue_nxt;

  logic             accept_c;
  logic [15:0]      crc_shift_c;
  logic             len_bad_c;
  logic             addr_hit_c;

  assign accept_c    = (state == IDLE) && in_valid;
  assign crc_shift_c = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  assign len_bad_c   = (count < LEN_MIN) || (count > LEN_MAX);
  assign addr_hit_c  = (addr == SLAVE_ADDR) || (addr == 8'h00);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a frame_end with an empty frame is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c)                               state_nxt = SHIFT;
        else if (frame_end && (count != '0))        state_nxt = CHECK;
      end
      SHIFT: begin
        if (bitcnt == 3'd7) state_nxt = (end_pend || frame_end) ? CHECK : IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result next values
  always_comb begin
    crc_nxt         = crc;
    count_nxt       = count;
    addr_nxt        = addr;
    bitcnt_nxt      = bitcnt;
    end_pend_nxt    = end_pend;
    err_pend_nxt    = err_pend || rx_err;
    done_nxt        = 1'b0;
    frame_ok_nxt    = frame_ok;
    crc_err_nxt     = crc_err;
    len_err_nxt     = len_err;
    err_seen_nxt    = err_seen;
    addr_match_nxt  = addr_match;
    broadcast_nxt   = broadcast;
    frame_len_nxt   = frame_len;
    crc_residue_nxt = crc_residue;
    in_ready_nxt    = (state_nxt == IDLE);
    case (state)
      IDLE: begin
        if (accept_c) begin
          crc_nxt      = {crc[15:8], crc[7:0] ^ in_byte};
          count_nxt    = (count == LEN_SAT) ? count : count + LEN_W'(1);
          bitcnt_nxt   = 3'd0;
          end_pend_nxt = end_pend || frame_end;
          if (count == '0) addr_nxt = in_byte;
        end
      end
      SHIFT: begin
        crc_nxt      = crc_shift_c;
        bitcnt_nxt   = bitcnt + 3'd1;
        end_pend_nxt = end_pend || frame_end;
      end
      CHECK: begin
        done_nxt        = 1'b1;
        crc_err_nxt     = (crc != 16'h0000);
        len_err_nxt     = len_bad_c;
        err_seen_nxt    = err_pend;
        addr_match_nxt  = addr_hit_c;
        broadcast_nxt   = (addr == 8'h00);
        frame_len_nxt   = count;
        crc_residue_nxt = crc;
        frame_ok_nxt    = (crc == 16'h0000) && !len_bad_c && !err_pend && addr_hit_c;
        crc_nxt         = CRC_INIT;
        count_nxt       = '0;
        end_pend_nxt    = 1'b0;
        // rx_err landing on the CHECK cycle belongs to the next frame
        err_pend_nxt    = rx_err;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      crc         <= CRC_INIT;
      count       <= '0;
      addr        <= 8'h00;
      bitcnt      <= 3'd0;
      end_pend    <= 1'b0;
      err_pend    <= 1'b0;
      in_ready    <= 1'b1;
      done        <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      err_seen    <= 1'b0;
      addr_match  <= 1'b0;
      broadcast   <= 1'b0;
      frame_len   <= '0;
      crc_residue <= 16'h0000;
    end else begin
      crc         <= crc_nxt;
      count       <= count_nxt;
      addr        <= addr_nxt;
      bitcnt      <= bitcnt_nxt;
      end_pend    <= end_pend_nxt;
      err_pend    <= err_pend_nxt;
      in_ready    <= in_ready_nxt;
      done        <= done_nxt;
      frame_ok    <= frame_ok_nxt;
      crc_err     <= crc_err_nxt;
      len_err     <= len_err_nxt;
      err_seen    <= err_seen_nxt;
      addr_match  <= addr_match_nxt;
      broadcast   <= broadcast_nxt;
      frame_len   <= frame_len_nxt;
      crc_residue <= crc_residue_nxt;
    end
  end

endmodule

// File: tb/tb_modbus_rtu_frame_check.sv
// Bench for modbus_rtu_frame_check: directed and random frames against a
// byte-level Modbus CRC/length/address reference model.
module tb_modbus_rtu_frame_check;

  localparam logic [7:0] SLAVE = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid, in_ready, rx_err, frame_end;
  logic       done, frame_ok, crc_err, len_err, err_seen, addr_match, broadcast;
  logic [8:0] frame_len;
  logic [15:0] crc_residue;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  modbus_rtu_frame_check #(.SLAVE_ADDR(SLAVE), .MIN_LEN(4), .MAX_LEN(256), .LEN_W(9)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .rx_err(rx_err), .frame_end(frame_end), .done(done), .frame_ok(frame_ok),
    .crc_err(crc_err), .len_err(len_err), .err_seen(err_seen), .addr_match(addr_match),
    .broadcast(broadcast), .frame_len(frame_len), .crc_residue(crc_residue)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard Modbus CRC-16 over a byte list
  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit err);
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_byte  = b;
    in_valid = 1'b1;
    rx_err   = err;
    @(negedge clk);
    in_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int err_idx);
    foreach (q[i]) send_byte(q[i], i == err_idx);
  endtask

  task automatic check_results(input string tag, input logic [7:0] q[$], input bit err);
    int n = q.size();
    logic [15:0] res = crc_of(q);
    logic [7:0]  a   = q[0];
    bit lerr = (n < 4) || (n > 256);
    bit am   = (a == SLAVE) || (a == 8'h00);
    chk({tag, ":residue"},   32'(crc_residue), 32'(res));
    chk({tag, ":crc_err"},   32'(crc_err), 32'(res != 16'h0000));
    chk({tag, ":frame_len"}, 32'(frame_len), 32'((n > 257) ? 257 : n));
    chk({tag, ":len_err"},   32'(len_err), 32'(lerr));
    chk({tag, ":err_seen"},  32'(err_seen), 32'(err));
    chk({tag, ":addr_match"},32'(addr_match), 32'(am));
    chk({tag, ":broadcast"}, 32'(broadcast), 32'(a == 8'h00));
    chk({tag, ":frame_ok"},  32'(frame_ok), 32'((res == 16'h0000) && !lerr && !err && am));
  endtask

  // Pulse frame_end, expect exactly one done, then compare held results
  task automatic finish_frame(input string tag, input logic [7:0] q[$], input bit err);
    int start = done_cnt;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    for (int k = 0; k < 30 && done_cnt == start; k++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk({tag, ":done_count"}, 32'(done_cnt - start), 32'd1);
    check_results(tag, q, err);
  endtask

  function automatic void add_crc(inout logic [7:0] q[$]);
    logic [15:0] c = crc_of(q);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endfunction

  initial begin
    logic [7:0] q[$];
    int start, lat, n, err_idx, gap;

    reset = 1'b1; in_byte = 8'h00; in_valid = 1'b0; rx_err = 1'b0; frame_end = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset:in_ready", 32'(in_ready), 32'd1);
    chk("reset:done", 32'(done), 32'd0);
    chk("reset:frame_ok", 32'(frame_ok), 32'd0);
    chk("reset:frame_len", 32'(frame_len), 32'd0);
    chk("reset:residue", 32'(crc_residue), 32'd0);

    // Canonical read-holding-registers request
    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    chk("case1:model_crc", 32'(crc_of(q)), 32'h0);
    send_frame(q, -1);
    repeat (10) @(negedge clk);
    finish_frame("case1", q, 1'b0);

    q[7] = 8'h0B;
    send_frame(q, -1);
    finish_frame("case2", q, 1'b0);

    q = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03}; add_crc(q);
    send_frame(q, -1);
    finish_frame("case3_bcast", q, 1'b0);
    q = '{8'h05, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03}; add_crc(q);
    send_frame(q, -1);
    finish_frame("case3_other", q, 1'b0);

    // frame_end during SHIFT of the last byte: done 10 negedges after the accept strobe
    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    for (int i = 0; i < 7; i++) send_byte(q[i], 1'b0);
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    in_byte = q[7]; in_valid = 1'b1;
    start = done_cnt; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      frame_end = (k == 3);
      if (done && lat == 0) lat = k;
    end
    frame_end = 1'b0;
    chk("case4:latency", 32'(lat), 32'd10);
    chk("case4:done_count", 32'(done_cnt - start), 32'd1);
    check_results("case4", q, 1'b0);

    q = '{8'h01, 8'h03, 8'h00};
    send_frame(q, -1);
    finish_frame("case5_short", q, 1'b0);

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(8'($urandom));
    q[0] = SLAVE;
    send_frame(q, -1);
    finish_frame("case5_long", q, 1'b0);

    start = done_cnt;
    frame_end = 1'b1; @(negedge clk); frame_end = 1'b0;
    repeat (20) @(negedge clk);
    chk("case5_empty:no_done", 32'(done_cnt - start), 32'd0);

    q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    send_frame(q, 3);
    finish_frame("case6_rxerr", q, 1'b1);

    // Reset during SHIFT aborts the frame silently
    start = done_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("case6_reset:in_ready", 32'(in_ready), 32'd1);
    chk("case6_reset:frame_len", 32'(frame_len), 32'd0);
    repeat (15) @(negedge clk);
    chk("case6_reset:no_done", 32'(done_cnt - start), 32'd0);
    send_frame(q, -1);
    finish_frame("case6_clean", q, 1'b0);

    // Random frames: address mix, optional corruption, rx_err and idle gaps
    for (int f = 0; f < 24; f++) begin
      q = {};
      n = $urandom_range(1, 16);
      case ($urandom_range(0, 3))
        0: q.push_back(SLAVE);
        1: q.push_back(8'h00);
        2: q.push_back(8'h05);
        default: q.push_back(8'($urandom));
      endcase
      for (int i = 1; i < n; i++) q.push_back(8'($urandom));
      add_crc(q);
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, q.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      err_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      send_frame(q, err_idx);
      gap = $urandom_range(0, 12);
      repeat (gap) @(negedge clk);
      finish_frame($sformatf("rand%0d", f), q, err_idx >= 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
